// File: rtl/i2c_if.sv
// i2c_if: byte-level command/status bundle between a local controller and
// the I2C master core.
//   start, stop, write, read : command levels from the controller
//   data_in, ack_in          : byte to send / ACK bit to send after a read
//   done, busy, ack_err      : status back to the controller
//   data_out                 : last byte read from the bus
// Handshake: commands are plain levels sampled only while the core sits in
// IDLE (start only) or HOLD (start > stop > write > read); at any other time
// they are ignored. A command counts as accepted on the clock edge where the
// core leaves IDLE/HOLD. done pulses for one clock when a byte plus its ACK
// bit has finished, and the core is back in HOLD in that same clock.
// The controller should drop a command level before the next HOLD, otherwise
// it is accepted again.
`timescale 1ns/1ps
interface i2c_if;
  logic       start;
  logic       stop;
  logic       write;
  logic       read;
  logic [7:0] data_in;
  logic       ack_in;
  logic       done;
  logic       busy;
  logic       ack_err;
  logic [7:0] data_out;

  // Controller side.
  modport master (
    output start, stop, write, read, data_in, ack_in,
    input  done, busy, ack_err, data_out
  );

  // Core side.
  modport slave (
    input  start, stop, write, read, data_in, ack_in,
    output done, busy, ack_err, data_out
  );
endinterface

// File: rtl/i2c_top.sv
// i2c_top: single-master I2C controller with a byte-level command interface
// (START, WRITE byte, READ byte with ACK/NACK, repeated START, STOP).
//   clk, reset (async, active low)
//   start/stop/write/read/data_in/ack_in : commands (see i2c_if)
//   sda (open drain, external pull-up), scl
//   done/busy/ack_err/data_out           : status
// i2c_master holds the FSM and bit timer; i2c_top adds the SDA pad.
`timescale 1ns/1ps
module i2c_master #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int I2C_FREQ = 100_000
) (
  input  logic clk,
  input  logic reset,
  i2c_if.slave cmd,
  input  logic sda_in,
  output logic scl,
  output logic out_sda,
  output logic out_sda_en
);
  localparam int QTR = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;

  // Encoding is observed externally; keep values fixed.
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    START      = 4'd1,
    HOLD       = 4'd2,
    WRITE_DATA = 4'd3,
    READ_DATA  = 4'd4,
    WAIT_ACK   = 4'd5,
    SEND_ACK   = 4'd6,
    STOP       = 4'd7
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [QW-1:0] qcnt;
  logic [1:0]    phase;
  logic [2:0]    bit_cnt;
  logic          wr_l;
  logic          rd_l;
  logic [7:0]    data_l;
  logic          ack_l;
  logic [7:0]    rx_sr;
  logic          done_q;
  logic          ack_err_q;
  logic [7:0]    data_out_q;
  logic          scl_d;
  logic          sda_d;
  logic          timed;
  logic          qtick;
  logic          sample;
  logic          bit_end;
  logic          scl_pulse;

  // The quarter timer only runs in states that move the bus.
  assign timed     = !(state == IDLE || state == HOLD);
  assign qtick     = (qcnt == QW'(QTR - 1));
  assign sample    = qtick && (phase == 2'd1);
  assign bit_end   = qtick && (phase == 2'd3);
  assign scl_pulse = (phase == 2'd1) || (phase == 2'd2);

  assign out_sda_en   = !(state == READ_DATA || state == WAIT_ACK);
  assign cmd.busy     = (state != IDLE);
  assign cmd.done     = done_q;
  assign cmd.ack_err  = ack_err_q;
  assign cmd.data_out = data_out_q;

  always_comb begin
    state_next = state;
    scl_d      = scl;
    sda_d      = out_sda;
    case (state)
      IDLE: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        if (cmd.start) state_next = START;
      end
      START: begin
        // q0 keeps SCL where it was: high from IDLE, low for a repeated
        // START, so SDA is released high while SCL is still low.
        case (phase)
          2'd0:    sda_d = 1'b1;
          2'd1:    begin scl_d = 1'b1; sda_d = 1'b1; end
          2'd2:    begin scl_d = 1'b1; sda_d = 1'b0; end
          default: begin scl_d = 1'b0; sda_d = 1'b0; end
        endcase
        if (bit_end) begin
          if (wr_l)      state_next = WRITE_DATA;
          else if (rd_l) state_next = READ_DATA;
          else           state_next = HOLD;
        end
      end
      HOLD: begin
        scl_d = 1'b0;
        if (cmd.start)      state_next = START;
        else if (cmd.stop)  state_next = STOP;
        else if (cmd.write) state_next = WRITE_DATA;
        else if (cmd.read)  state_next = READ_DATA;
      end
      WRITE_DATA: begin
        scl_d = scl_pulse;
        sda_d = data_l[~bit_cnt];  // MSB first: data[7 - bit_cnt]
        if (bit_end && bit_cnt == 3'd7) state_next = WAIT_ACK;
      end
      READ_DATA: begin
        scl_d = scl_pulse;
        sda_d = 1'b1;
        if (bit_end && bit_cnt == 3'd7) state_next = SEND_ACK;
      end
      WAIT_ACK: begin
        scl_d = scl_pulse;
        sda_d = 1'b1;
        if (bit_end) state_next = HOLD;
      end
      SEND_ACK: begin
        scl_d = scl_pulse;
        sda_d = ack_l;
        if (bit_end) state_next = HOLD;
      end
      STOP: begin
        case (phase)
          2'd0:    begin scl_d = 1'b0; sda_d = 1'b0; end
          2'd1:    begin scl_d = 1'b1; sda_d = 1'b0; end
          default: begin scl_d = 1'b1; sda_d = 1'b1; end
        endcase
        if (bit_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qcnt       <= '0;
      phase      <= 2'd0;
      bit_cnt    <= 3'd0;
      wr_l       <= 1'b0;
      rd_l       <= 1'b0;
      data_l     <= 8'h00;
      ack_l      <= 1'b0;
      rx_sr      <= 8'h00;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      data_out_q <= 8'h00;
      scl        <= 1'b1;
      out_sda    <= 1'b1;
    end else begin
      scl     <= scl_d;
      out_sda <= sda_d;

      if (!timed) begin
        qcnt  <= '0;
        phase <= 2'd0;
      end else if (qtick) begin
        qcnt  <= '0;
        phase <= phase + 2'd1;
      end else begin
        qcnt <= qcnt + QW'(1);
      end

      // Advances on the edge that starts the next bit's q0; wraps 7 -> 0.
      if (!timed) begin
        bit_cnt <= 3'd0;
      end else if ((state == WRITE_DATA || state == READ_DATA) && bit_end) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if ((state == IDLE || state == HOLD) && cmd.start) begin
        wr_l   <= cmd.write;
        rd_l   <= cmd.read;
        data_l <= cmd.data_in;
        ack_l  <= cmd.ack_in;
      end else if (state == HOLD && !cmd.stop && cmd.write) begin
        data_l <= cmd.data_in;
      end else if (state == HOLD && !cmd.stop && cmd.read) begin
        ack_l <= cmd.ack_in;
      end

      if (state_next == WRITE_DATA && state != WRITE_DATA) begin
        ack_err_q <= 1'b0;
      end else if (state == WAIT_ACK && sample) begin
        ack_err_q <= sda_in;
      end

      if (state == READ_DATA && sample) begin
        rx_sr <= {rx_sr[6:0], sda_in};
      end

      // done and data_out change on the same edge so the byte is valid
      // exactly when done is seen.
      done_q <= bit_end && (state == WAIT_ACK || state == SEND_ACK);
      if (state == SEND_ACK && bit_end) begin
        data_out_q <= rx_sr;
      end
    end
  end
endmodule

module i2c_top #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int I2C_FREQ = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       write,
  input  logic       read,
  input  logic [7:0] data_in,
  input  logic       ack_in,
  inout  wire        sda,
  output logic       scl,
  output logic       done,
  output logic       busy,
  output logic       ack_err,
  output logic [7:0] data_out
);
  logic out_sda;
  logic out_sda_en;

  i2c_if cmd_if ();

  assign cmd_if.start   = start;
  assign cmd_if.stop    = stop;
  assign cmd_if.write   = write;
  assign cmd_if.read    = read;
  assign cmd_if.data_in = data_in;
  assign cmd_if.ack_in  = ack_in;
  assign done           = cmd_if.done;
  assign busy           = cmd_if.busy;
  assign ack_err        = cmd_if.ack_err;
  assign data_out       = cmd_if.data_out;

  i2c_master #(
    .CLK_FREQ (CLK_FREQ),
    .I2C_FREQ (I2C_FREQ)
  ) U_i2c_master (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd_if),
    .sda_in     (sda),
    .scl        (scl),
    .out_sda    (out_sda),
    .out_sda_en (out_sda_en)
  );

  // Open-drain style pad: released SDA is pulled high externally.
  assign sda = out_sda_en ? out_sda : 1'bz;
endmodule

// File: tb/tb_i2c_top.sv
// tb_i2c_top: directed bench for i2c_top with a bus-level slave model and
// a bus monitor that decodes START/STOP and 9-bit byte frames from SCL/SDA.
`timescale 1ns/1ps
module tb_i2c_top;
  logic       clk = 1'b0;
  logic       reset;
  wire        sda;
  logic       scl;
  logic       done;
  logic       busy;
  logic       ack_err;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  i2c_if tb_if ();

  i2c_top dut (
    .clk      (clk),
    .reset    (reset),
    .start    (tb_if.start),
    .stop     (tb_if.stop),
    .write    (tb_if.write),
    .read     (tb_if.read),
    .data_in  (tb_if.data_in),
    .ack_in   (tb_if.ack_in),
    .sda      (sda),
    .scl      (scl),
    .done     (done),
    .busy     (busy),
    .ack_err  (ack_err),
    .data_out (data_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  logic       slave_ack = 1'b0;   // pull SDA low in the write ACK slot
  logic       slave_rd  = 1'b0;   // drive slave_byte during read bits
  logic [7:0] slave_byte = 8'h00;
  int         drv_idx = 0;        // bit slot currently on the bus
  logic       want_low;
  logic       slave_low;

  pullup (sda);
  always_comb begin
    want_low = 1'b0;
    if (slave_rd && drv_idx < 8) want_low = !slave_byte[7 - drv_idx];
    else if (slave_ack && drv_idx == 8) want_low = 1'b1;
    slave_low = want_low && !dut.U_i2c_master.out_sda_en;
  end
  assign sda = slave_low ? 1'b0 : 1'bz;

  // ---------------- bus monitor ----------------
  int         bitpos = 0;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         byte_cnt = 0;
  logic [8:0] sh = 9'h0;
  logic [7:0] mon_byte = 8'h00;
  logic       mon_ack = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;

  always @(negedge clk) begin
    if (scl && prev_scl && prev_sda && !sda) begin
      start_cnt++;
      bitpos  = 0;
      drv_idx = 0;
    end else if (scl && prev_scl && !prev_sda && sda) begin
      stop_cnt++;
      bitpos  = 0;
      drv_idx = 0;
    end else if (scl && !prev_scl) begin
      sh = {sh[7:0], sda};
      bitpos++;
      if (bitpos == 9) begin
        mon_byte = sh[8:1];
        mon_ack  = sh[0];
        byte_cnt++;
        bitpos = 0;
      end
    end else if (!scl && prev_scl) begin
      drv_idx = bitpos;
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic s, input logic p, input logic w,
                       input logic r, input logic [7:0] d, input logic a);
    tb_if.start   = s;
    tb_if.stop    = p;
    tb_if.write   = w;
    tb_if.read    = r;
    tb_if.data_in = d;
    tb_if.ack_in  = a;
    @(negedge clk);
    tb_if.start = 1'b0;
    tb_if.stop  = 1'b0;
    tb_if.write = 1'b0;
    tb_if.read  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 12000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: done=%b after %0d clk, required 1", name, done, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset         = 1'b0;
    tb_if.start   = 1'b0;
    tb_if.stop    = 1'b0;
    tb_if.write   = 1'b0;
    tb_if.read    = 1'b0;
    tb_if.data_in = 8'h00;
    tb_if.ack_in  = 1'b0;
    #100;
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b required 1", scl); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b required 1", sda); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h required 00", data_out); end
    checks++; if (dut.U_i2c_master.state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", dut.U_i2c_master.state); end
    checks++; if (dut.U_i2c_master.out_sda_en !== 1'b1) begin errors++; $display("FAIL reset_sda_en: got %b required 1", dut.U_i2c_master.out_sda_en); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    slave_ack = 1'b1;
    slave_rd  = 1'b0;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 8'hA0, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_rise: got %b required 1", busy); end
    wait_done("write_a0");
    checks++; if (mon_byte !== 8'hA0) begin errors++; $display("FAIL write_a0_bus: got %h required a0", mon_byte); end
    checks++; if (mon_ack !== 1'b0) begin errors++; $display("FAIL write_a0_ack_bit: got %b required 0", mon_ack); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL write_a0_ack_err: got %b required 0", ack_err); end
    checks++; if (start_cnt !== 1) begin errors++; $display("FAIL write_a0_start: got %0d required 1", start_cnt); end
    checks++; if (dut.U_i2c_master.state !== 4'd2) begin errors++; $display("FAIL write_a0_hold: got %0d required 2", dut.U_i2c_master.state); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL write_a0_done_width: got %b required 0", done); end

    issue(1'b0, 1'b0, 1'b1, 1'b0, 8'hAA, 1'b0);
    wait_done("write_aa");
    checks++; if (mon_byte !== 8'hAA) begin errors++; $display("FAIL write_aa_bus: got %h required aa", mon_byte); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL write_aa_ack_err: got %b required 0", ack_err); end
    checks++; if (start_cnt !== 1) begin errors++; $display("FAIL write_aa_no_start: got %0d required 1", start_cnt); end
    checks++; if (byte_cnt !== 2) begin errors++; $display("FAIL write_aa_bytes: got %0d required 2", byte_cnt); end
  endtask

  task automatic test_read_rep();
    slave_ack  = 1'b0;
    slave_rd   = 1'b1;
    slave_byte = 8'h11;
    issue(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (dut.U_i2c_master.state !== 4'd1) begin errors++; $display("FAIL rep_start_state: got %0d required 1", dut.U_i2c_master.state); end
    wait_done("read_11");
    checks++; if (start_cnt !== 2) begin errors++; $display("FAIL rep_start_bus: got %0d required 2", start_cnt); end
    checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL read_11_data: got %h required 11", data_out); end
    checks++; if (mon_ack !== 1'b0) begin errors++; $display("FAIL read_11_master_ack: got %b required 0", mon_ack); end
  endtask

  task automatic test_back_to_back_reads();
    slave_byte = 8'h22;
    issue(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    wait_done("read_22");
    checks++; if (data_out !== 8'h22) begin errors++; $display("FAIL read_22_data: got %h required 22", data_out); end
    checks++; if (mon_ack !== 1'b0) begin errors++; $display("FAIL read_22_master_ack: got %b required 0", mon_ack); end
    slave_byte = 8'h33;
    issue(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    wait_done("read_33");
    checks++; if (data_out !== 8'h33) begin errors++; $display("FAIL read_33_data: got %h required 33", data_out); end
    checks++; if (mon_ack !== 1'b1) begin errors++; $display("FAIL read_33_master_nack: got %b required 1", mon_ack); end
    checks++; if (mon_byte !== 8'h33) begin errors++; $display("FAIL read_33_bus: got %h required 33", mon_byte); end
  endtask

  task automatic test_stop();
    int n;
    int stops0;
    int starts0;
    logic busy_seen;
    slave_rd = 1'b0;
    stops0   = stop_cnt;
    tb_if.stop = 1'b1;
    repeat (300) @(negedge clk);
    tb_if.stop = 1'b0;
    n = 300;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    // STOP is four quarters of 250 clk, accepted on the first edge.
    checks++; if (n < 1000 || n > 1002) begin errors++; $display("FAIL stop_busy_fall: busy low after %0d clk, required 1001", n); end
    checks++; if (stop_cnt !== stops0 + 1) begin errors++; $display("FAIL stop_bus: got %0d stops required %0d", stop_cnt, stops0 + 1); end
    checks++; if (scl !== 1'b1 || sda !== 1'b1) begin errors++; $display("FAIL stop_idle_bus: scl=%b sda=%b required 1 1", scl, sda); end

    // A stop level in IDLE must not wake the FSM.
    starts0   = start_cnt;
    busy_seen = 1'b0;
    tb_if.stop = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    tb_if.stop = 1'b0;
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL stop_in_idle_busy: got %b required 0", busy_seen); end
    checks++; if (start_cnt !== starts0 || stop_cnt !== stops0 + 1) begin errors++; $display("FAIL stop_in_idle_bus: starts %0d stops %0d required %0d %0d", start_cnt, stop_cnt, starts0, stops0 + 1); end
  endtask

  task automatic test_nack();
    slave_ack = 1'b0;
    slave_rd  = 1'b0;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 8'h5C, 1'b0);
    wait_done("write_5c");
    checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL nack_ack_err: got %b required 1", ack_err); end
    checks++; if (mon_byte !== 8'h5C) begin errors++; $display("FAIL nack_bus: got %h required 5c", mon_byte); end
    checks++; if (mon_ack !== 1'b1) begin errors++; $display("FAIL nack_ack_bit: got %b required 1", mon_ack); end
  endtask

  task automatic test_reset_mid();
    slave_ack = 1'b1;
    issue(1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0);
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL ack_err_clear: got %b required 0", ack_err); end
    checks++; if (dut.U_i2c_master.state !== 4'd3) begin errors++; $display("FAIL mid_write_state: got %0d required 3", dut.U_i2c_master.state); end
    repeat (3100) @(negedge clk);
    checks++; if (dut.U_i2c_master.bit_cnt !== 3'd3) begin errors++; $display("FAIL mid_bit_cnt: got %0d required 3", dut.U_i2c_master.bit_cnt); end
    reset = 1'b0;
    #1;
    checks++; if (dut.U_i2c_master.state !== 4'd0) begin errors++; $display("FAIL abort_state: got %0d required 0", dut.U_i2c_master.state); end
    checks++; if (scl !== 1'b1 || sda !== 1'b1) begin errors++; $display("FAIL abort_bus: scl=%b sda=%b required 1 1", scl, sda); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_status: busy=%b done=%b required 0 0", busy, done); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL abort_data_out: got %h required 00", data_out); end
    checks++; if (dut.U_i2c_master.bit_cnt !== 3'd0) begin errors++; $display("FAIL abort_bit_cnt: got %0d required 0", dut.U_i2c_master.bit_cnt); end
    checks++; if (dut.U_i2c_master.out_sda_en !== 1'b1) begin errors++; $display("FAIL abort_sda_en: got %b required 1", dut.U_i2c_master.out_sda_en); end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write();
    test_read_rep();
    test_back_to_back_reads();
    test_stop();
    test_nack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/i2c_top.md
Name: i2c_top

Overview:
- Single-master I2C controller with a byte-level command interface: START, WRITE byte, READ byte (with master ACK/NACK), repeated START and STOP.
- Consists of a core instance U_i2c_master (module i2c_master), which holds the FSM, plus open-drain SDA/SCL pad logic.
- Sits between a local controller (e.g. a peripheral init sequencer) and external I2C slaves.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- I2C_FREQ, 100_000, SCL frequency in Hz.
- QTR = CLK_FREQ/(4*I2C_FREQ) is derived, not overridable. It gives 250 clk per quarter-bit.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request START (from IDLE) or repeated START (from HOLD); level-sampled.
- stop  input  1  request STOP from HOLD.
- write  input  1  request byte write of data_in.
- read  input  1  request byte read; ack_in selects the ACK bit the master sends.
- data_in  input  8  byte to transmit, MSB first.
- ack_in  input  1  master ACK bit after a read: 0 = ACK (more reads follow), 1 = NACK (last byte).
- sda  inout  1  I2C data; an external pull-up is assumed.
- scl  output  1  I2C clock.
- done  output  1  one-clk pulse when a byte, including its ACK bit, completes.
- busy  output  1  high whenever the FSM is not in IDLE.
- ack_err  output  1  set if the slave NACKed the last written byte.
- data_out  output  8  last byte read.

Behaviour:
- Reset (async, reset=0): state=IDLE, scl=1, SDA driven 1 (out_sda_en=1, out_sda=1), done=0, busy=0, ack_err=0, data_out=0, bit_cnt=0, all latches cleared.

Pad logic:
- sda = out_sda_en ? out_sda : Z.
- out_sda_en must be 0 exactly in READ_DATA and WAIT_ACK, and 1 in every other state.
- Verification probes U_i2c_master.state, U_i2c_master.bit_cnt and U_i2c_master.out_sda_en; names and encodings are fixed.

State encoding (4-bit state):
- IDLE=0, START=1, HOLD=2, WRITE_DATA=3, READ_DATA=4, WAIT_ACK=5, SEND_ACK=6, STOP=7.

Bit timing:
- Each bit is four quarter phases of QTR clocks: q0 SCL low (SDA changes here), q1 SCL high, q2 SCL high, q3 SCL low.
- SDA is sampled at the q1→q2 boundary.
- bit_cnt (3-bit, 0..7) counts bits MSB first and changes only in q0 (SCL low).
- Transmitted bit is data[7-bit_cnt].

Transitions:
- IDLE: on start=1, latch write, read, data_in and ack_in, then go to START. Other inputs are ignored.
- START:
  - SDA=1, then SCL=1, then SDA=0 while SCL high, then SCL=0, one quarter each.
  - The same sequence performs a repeated START from HOLD; SDA is released high while SCL is still low.
  - Exit: latched write → WRITE_DATA; else latched read → READ_DATA; else → HOLD.
- HOLD: SCL low, SDA held. Priority start > stop > write > read.
  - start: latch write/read/data_in/ack_in → START.
  - stop → STOP.
  - write: latch data_in → WRITE_DATA.
  - read: latch ack_in → READ_DATA.
- WRITE_DATA: shift out 8 bits → WAIT_ACK.
- WAIT_ACK: one bit with SDA released.
  - ack_err = sampled SDA (1 = NACK).
  - Pulse done in the last clk → HOLD.
- READ_DATA: SDA released; shift in 8 sampled bits → SEND_ACK.
- SEND_ACK: drive latched ack_in for one bit.
  - data_out = received byte, updated together with the done pulse → HOLD.
- STOP:
  - SDA=0 (SCL low), then SCL=1, then SDA=1 while SCL high, one quarter each.
  - → IDLE; busy falls here.
- A stop level still asserted on return to IDLE is ignored.

Edge cases and timing:
- ack_err clears when a new write begins.
- Commands asserted during a byte transfer are ignored; only HOLD samples them.
- Reset mid-transfer aborts immediately to the reset values (no STOP is generated).
- busy rises the clk after start is accepted.
- Byte latency is 9 bits × 4 × QTR = 9000 clk at the default parameters.

Test Plan:
1. Reset low 100 ns, release → scl=1, sda=1, busy=0, done=0, data_out=0x00.
2. start+write with data_in=0xA0, slave ACKs → bus shows START then 1010_0000 MSB first; done pulses once; ack_err=0; state returns to HOLD. Then write 0xAA → done, ack_err=0.
3. From HOLD, start+read with ack_in=0, slave sends 0x11 → repeated START seen (state passes through 1); data_out=0x11; master drives SDA=0 in the ACK slot.
4. Read with ack_in=0 (slave 0x22), then read with ack_in=1 (slave 0x33) → data_out=0x22, then 0x33; last ACK slot has SDA=1 (NACK).
5. stop held high 3 µs → STOP condition (SDA rises while SCL high); busy=0 about 1 bit time later; no further activity while stop stays high.
6. Write 0x5C with SDA left floating (no slave ACK) → ack_err=1 after done. Separately, assert reset mid-byte → immediate IDLE with reset values.
